// File: rtl/corr_sequencer_pkg.sv
// Shared types for the correlator master sequencer.
//   state_t      : sequencer state encoding (3-bit)
//   is_windowed  : true in the states where the shared window counter runs
package corr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_windowed(input state_t s);
        return (s == ST_FILL) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/corr_sequencer_sob_counter.sv
// Shared window counter for the correlator lanes.
// Counts SOB_MAX, 1, 2, ..., SOB_MAX-1 and repeats, so it never shows 0
// while running; 0 only appears after clr (idle).
//   clk, rst : clock, async active-high reset
//   clr      : force value to 0 (highest priority)
//   load     : force value to SOB_MAX (start of the first window)
//   en       : advance one step
//   value    : current counter value (WIDTH+1 bits)
//   wrap     : value == SOB_MAX-1, i.e. last cycle of a window
module corr_sequencer_sob_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH:0]   value,
    output logic             wrap
);

    localparam logic [WIDTH:0] SOB_MAX  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] SOB_LAST = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= SOB_MAX;
        end else if (en) begin
            if (value == SOB_LAST)
                value <= SOB_MAX;
            else if (value == SOB_MAX)
                value <= ONE;
            else
                value <= value + ONE;
        end
    end

    assign wrap = (value == SOB_LAST);

endmodule

// File: rtl/corr_sequencer.sv
// Master sequencer for stochastic-bitstream correlator lanes sharing one
// window counter. Runs a burst of num_windows windows of 2**WIDTH bits as
// FILL -> RUN -> DRAIN -> DONE, because the lanes regenerate one window
// behind the input.
//   clk, rst     : clock, async active-high reset
//   start        : begin a burst (IDLE and num_windows != 0 only)
//   abort        : synchronous abort, overrides everything
//   num_windows  : burst length, sampled on an accepted start
//   counter_sob  : shared window counter to all lanes
//   in_ready     : input bit consumed this cycle
//   corr_en      : lane output-register enable
//   out_valid    : corr_en delayed one cycle
//   win_idx      : index of the window being regenerated
//   busy         : not idle
//   done         : one-cycle pulse at the end of a completed burst
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, counter at 0
// ST_FILL  | first window: load input only, no regeneration
// ST_RUN   | load next window while regenerating the previous one
// ST_DRAIN | regenerate the last window, no input consumed
// ST_DONE  | single cycle, done pulse, then back to idle
module corr_sequencer
    import corr_sequencer_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_windows,
    output logic [WIDTH:0]   counter_sob,
    output logic             in_ready,
    output logic             corr_en,
    output logic             out_valid,
    output logic [CNT_W-1:0] win_idx,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] n_win;
    logic             sob_wrap;
    logic             sob_clr;
    logic             start_ok;
    logic             last_run;

    assign start_ok = (state == ST_IDLE) && start && (num_windows != '0);
    // RUN covers windows 0..N-2; the DRAIN window is N-1. Only evaluated in
    // RUN, where N >= 2, so the subtraction cannot underflow.
    assign last_run = (win_idx == (n_win - CNT_W'(2)));
    // Abort takes priority inside the counter (clr beats load).
    assign sob_clr  = abort || (state == ST_DONE) ||
                      ((state == ST_DRAIN) && sob_wrap);

    corr_sequencer_sob_counter #(.WIDTH(WIDTH)) u_sob (
        .clk   (clk),
        .rst   (rst),
        .clr   (sob_clr),
        .load  (start_ok),
        .en    (is_windowed(state)),
        .value (counter_sob),
        .wrap  (sob_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            n_win     <= '0;
            in_ready  <= 1'b0;
            corr_en   <= 1'b0;
            out_valid <= 1'b0;
            win_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= corr_en;
            done      <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                in_ready <= 1'b0;
                corr_en  <= 1'b0;
                win_idx  <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            state    <= ST_FILL;
                            n_win    <= num_windows;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            win_idx  <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (sob_wrap) begin
                            corr_en <= 1'b1;
                            if (n_win > CNT_W'(1)) begin
                                state <= ST_RUN;
                            end else begin
                                state    <= ST_DRAIN;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (sob_wrap) begin
                            win_idx <= win_idx + CNT_W'(1);
                            if (last_run) begin
                                state    <= ST_DRAIN;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (sob_wrap) begin
                            state   <= ST_DONE;
                            corr_en <= 1'b0;
                            win_idx <= '0;
                            done    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                        corr_en  <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_sequencer.sv
// Scoreboard bench for corr_sequencer (WIDTH=3, 8-cycle windows).
// The driver applies one input set per cycle and a reference model, which
// derives every output from the cycle offset inside the burst, pushes the
// expected outputs of the following cycle; a monitor pops and compares.
module tb_corr_sequencer;

    localparam int WIDTH = 3;
    localparam int CNT_W = 16;
    localparam int WIN   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_windows;
    logic [WIDTH:0]   counter_sob;
    logic             in_ready;
    logic             corr_en;
    logic             out_valid;
    logic [CNT_W-1:0] win_idx;
    logic             busy;
    logic             done;

    corr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_windows (num_windows),
        .counter_sob (counter_sob),
        .in_ready    (in_ready),
        .corr_en     (corr_en),
        .out_valid   (out_valid),
        .win_idx     (win_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH:0]   sob;
        logic             in_ready;
        logic             corr_en;
        logic             out_valid;
        logic [CNT_W-1:0] win_idx;
        logic             busy;
        logic             done;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: is a burst active, which cycle of it (1-based), length.
    bit   m_active  = 1'b0;
    int   m_k       = 0;
    int   m_n       = 0;
    logic m_prev_ce = 1'b0;

    function automatic obs_t obs_now();
        obs_t o;
        o.sob       = counter_sob;
        o.in_ready  = in_ready;
        o.corr_en   = corr_en;
        o.out_valid = out_valid;
        o.win_idx   = win_idx;
        o.busy      = busy;
        o.done      = done;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual sob=%0d ir=%0b ce=%0b ov=%0b wi=%0d busy=%0b done=%0b required sob=%0d ir=%0b ce=%0b ov=%0b wi=%0d busy=%0b done=%0b",
                     name, $time,
                     act.sob, act.in_ready, act.corr_en, act.out_valid, act.win_idx, act.busy, act.done,
                     req.sob, req.in_ready, req.corr_en, req.out_valid, req.win_idx, req.busy, req.done);
        end
    endtask

    // Outputs for burst cycle m_k: window w = (k-1)/WIN; window 0 is fill,
    // window N is drain, cycle WIN*(N+1)+1 is the done cycle.
    function automatic obs_t exp_now(input logic ov);
        obs_t e;
        int   w;
        int   pos;
        e = '0;
        e.out_valid = ov;
        if (m_active) begin
            e.busy = 1'b1;
            if (m_k == WIN * (m_n + 1) + 1) begin
                e.done = 1'b1;
            end else begin
                w   = (m_k - 1) / WIN;
                pos = (m_k - 1) % WIN;
                e.sob      = (pos == 0) ? (WIDTH+1)'(WIN) : (WIDTH+1)'(pos);
                e.in_ready = (w < m_n);
                e.corr_en  = (w >= 1);
                e.win_idx  = (w >= 1) ? CNT_W'(w - 1) : '0;
            end
        end
        return e;
    endfunction

    task automatic model_edge(input logic st, input logic ab, input logic rs,
                              input logic [CNT_W-1:0] nw);
        obs_t e;
        logic ov;
        ov = rs ? 1'b0 : m_prev_ce;
        if (rs || ab) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_k++;
            if (m_k > WIN * (m_n + 1) + 1)
                m_active = 1'b0;
        end else if (st && nw != '0) begin
            m_active = 1'b1;
            m_k      = 1;
            m_n      = int'(nw);
        end
        e = exp_now(ov);
        m_prev_ce = e.corr_en;
        exp_q.push_back(e);
    endtask

    // One cycle: drive just after the falling edge, model the rising edge.
    task automatic step(input logic st, input logic ab, input logic rs,
                        input logic [CNT_W-1:0] nw);
        @(negedge clk);
        #1;
        start       = st;
        abort       = ab;
        num_windows = nw;
        if (rs && !rst) begin
            rst = 1'b1;
            #1;
            check_obs("async_rst", obs_now(), '0);
        end else begin
            rst = rs;
        end
        @(posedge clk);
        model_edge(st, ab, rs, nw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_obs("cycle", obs_now(), e);
        end
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        num_windows = '0;
        #2;
        check_obs("reset", obs_now(), '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        idle(2);

        // N=3 with extra start pulses while busy
        step(1'b1, 1'b0, 1'b0, 16'd3);
        for (int i = 1; i <= 40; i++)
            step((i == 5 || i == 20 || i == 33), 1'b0, 1'b0, 16'd2);

        // N=1: fill then drain, no run
        step(1'b1, 1'b0, 1'b0, 16'd1);
        idle(22);

        // start with zero windows is ignored
        step(1'b1, 1'b0, 1'b0, 16'd0);
        idle(4);

        // abort at cycle 12 of an N=3 burst
        step(1'b1, 1'b0, 1'b0, 16'd3);
        idle(11);
        step(1'b0, 1'b1, 1'b0, '0);
        idle(4);

        // reset pulse at cycle 20, new start at cycle 30
        step(1'b1, 1'b0, 1'b0, 16'd3);
        idle(19);
        step(1'b0, 1'b0, 1'b1, '0);
        idle(9);
        step(1'b1, 1'b0, 1'b0, 16'd3);
        idle(40);

        // abort and start together: abort wins
        step(1'b1, 1'b1, 1'b0, 16'd2);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 199) == 0, CNT_W'($urandom_range(0, 4)));
        idle(50);

        @(negedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain actual %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
